prior_decoder3to8_seq: RTL and testbench
========================================

PRIOR_DECODER3TO8_SEQ -- requirements
Module: prior_decoder3to8_seq

Interface
REQ-001 Parameter: TIMEOUT, default 16, number of GRANT cycles without the matching ack before the grant is withdrawn; legal range 2..255.
REQ-002 Clocking is one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 v  input  1  code valid, from the 8-to-3 priority encoder.
REQ-006 y  input  3  encoded request index, 7 = highest priority.
REQ-007 ready  output  1  code acceptance; a code is accepted when v and ready are both 1 at a rising edge.
REQ-008 grant  output  8  registered one-hot grant to request line i; all zeros when no grant is active.
REQ-009 ack  input  8  per-line acknowledge; only ack[i] of the granted line is honoured.
REQ-010 busy  output  1  high while the state is GRANT or RECOVER.
REQ-011 timeout  output  1  one-cycle pulse when a grant is withdrawn without an ack.

Function
REQ-012 Accepted code y=k SHALL set pending[k] at that edge; setting an already-set bit has no effect.
REQ-013 ready SHALL be combinational: 0 when pending==8'hFF, otherwise 1.
REQ-014 FSM states SHALL be IDLE, GRANT and RECOVER, encoded in 2 bits; the unused encoding returns to IDLE on the next edge.
REQ-015 In IDLE with pending!=0, the edge SHALL do all of: latch idx = highest set pending bit; load grant = 1<<idx; clear cnt to 0; enter GRANT.
REQ-016 Latency: a code accepted at edge N into empty pending in IDLE SHALL produce grant at edge N+1, visible in cycle N+1.
REQ-017 In GRANT, cnt SHALL increment by 1 per cycle (8-bit, no wrap within the legal TIMEOUT range).
REQ-018 In GRANT, if ack[idx]=1, the edge SHALL do all of: clear pending[idx]; load grant = 0; enter RECOVER.
REQ-019 Simultaneous accept of y=idx and ack[idx] in the same cycle SHALL leave pending[idx] set.
REQ-020 In GRANT, if cnt==TIMEOUT-1 without ack[idx], the edge SHALL do all of: load grant = 0; keep pending[idx]; pulse timeout for one cycle; enter RECOVER.
REQ-021 ack[idx] in the cnt==TIMEOUT-1 cycle SHALL count as an ack, with no timeout pulse.
REQ-022 ack bits other than idx SHALL be ignored in every state; ack in IDLE or RECOVER SHALL be ignored.
REQ-023 A higher-priority code arriving during GRANT SHALL NOT preempt; it is served after RECOVER.
REQ-024 RECOVER SHALL last exactly one cycle, with grant=0, and then enter IDLE; this gives a minimum one-cycle gap between grants.
REQ-025 grant SHALL never have more than one bit set.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set: pending=0, state=IDLE, grant=0, cnt=0, idx=0, timeout=0.
REQ-027 busy SHALL read 0 after reset.
REQ-028 Codes presented while rst=1 SHALL be discarded.
REQ-029 Reset asserted during GRANT SHALL drop grant at that edge with no timeout pulse.

Structure
REQ-030 A shared package SHALL hold the state encoding constants and the TIMEOUT default.
REQ-031 A sub-module prior_pick8 (combinational highest-set-bit picker, 8-bit vector in, 3-bit index out) SHALL be instantiated; it is the only natural sub-module.

Verification
REQ-032 Reset, then v=1,y=5 for one cycle -> grant=8'h20 in the next cycle; ack[5]=1 two cycles later -> grant=0, then busy=0 one cycle after that.
REQ-033 Codes 2 and 6 accepted on consecutive cycles -> grant=8'h04 first (code 2 picked in IDLE); after ack[2] and RECOVER, grant=8'h40.
REQ-034 Grant 8'h08 held with no ack, TIMEOUT=4 -> grant drops after 4 cycles, timeout pulses once, pending[3] remains set, grant=8'h08 reissued after RECOVER.
REQ-035 During grant of 8'h02, drive ack=8'hFD -> no effect; then ack[1] together with v=1,y=1 -> grant drops and grant=8'h02 is reissued after RECOVER.
REQ-036 All eight codes accepted -> ready=0 once pending==8'hFF; grants issue in order 80,40,20,10,08,04,02,01.
REQ-037 rst=1 mid-GRANT -> grant=0 and pending=0 at the next edge; no timeout pulse.

Source files
------------

// File: rtl/prior_decoder3to8_seq_pkg.sv
// rtl/prior_decoder3to8_seq_pkg.sv - shared state encoding and defaults for the priority grant sequencer
package prior_decoder3to8_seq_pkg;

    // Default number of unacknowledged GRANT cycles before the grant is withdrawn.
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    // 2-bit state encoding; 2'd3 is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    // One-hot line select for a 3-bit index.
    function automatic logic [7:0] line_mask(input logic [2:0] i);
        return 8'd1 << i;
    endfunction

endpackage

// File: rtl/prior_pick8.sv
// rtl/prior_pick8.sv - combinational highest-set-bit picker
//
// Ports:
//   vec  in   8  candidate vector
//   idx  out  3  index of the highest set bit (0 when vec is zero)
//   any  out  1  vec has at least one bit set
module prior_pick8 (
    input  logic [7:0] vec,
    output logic [2:0] idx,
    output logic       any
);

    // Ascending scan: later (higher) set bits overwrite lower ones.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/prior_decoder3to8_seq.sv
// rtl/prior_decoder3to8_seq.sv - pending-request priority grant sequencer with ack timeout
//
// Ports:
//   clk      in   1  sole clock, rising edge
//   rst      in   1  synchronous active-high reset
//   v        in   1  code valid
//   y        in   3  encoded request index (7 = highest priority)
//   ready    out  1  code acceptance (0 only when every line is pending)
//   grant    out  8  registered one-hot grant, zero when idle
//   ack      in   8  per-line acknowledge, only the granted line is honoured
//   busy     out  1  state is GRANT or RECOVER
//   timeout  out  1  one-cycle pulse when a grant is withdrawn without ack
module prior_decoder3to8_seq
    import prior_decoder3to8_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       v,
    input  logic [2:0] y,
    output logic       ready,
    output logic [7:0] grant,
    input  logic [7:0] ack,
    output logic       busy,
    output logic       timeout
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] pending;
    logic [7:0] cnt;
    logic [2:0] idx;

    logic [2:0] pick_idx;
    logic       pick_any;
    logic       accept;
    logic       ack_hit;
    logic [7:0] set_mask;
    logic [7:0] clr_mask;

    prior_pick8 u_pick (
        .vec (pending),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign ready    = (pending != 8'hFF);
    assign busy     = (state == ST_GRANT) || (state == ST_RECOVER);
    assign accept   = v && ready;
    assign ack_hit  = (state == ST_GRANT) && ack[idx];
    assign set_mask = accept  ? line_mask(y)   : 8'd0;
    assign clr_mask = ack_hit ? line_mask(idx) : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 8'd0;
            state   <= ST_IDLE;
            grant   <= 8'd0;
            cnt     <= 8'd0;
            idx     <= 3'd0;
            timeout <= 1'b0;
        end else begin
            // Set is applied after clear so a re-request of the line being
            // acknowledged in the same cycle stays pending.
            pending <= (pending & ~clr_mask) | set_mask;
            timeout <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        idx   <= pick_idx;
                        grant <= line_mask(pick_idx);
                        cnt   <= 8'd0;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (ack_hit) begin
                        grant <= 8'd0;
                        state <= ST_RECOVER;
                    end else if (cnt == CNT_LAST) begin
                        // Request stays pending and is re-served after RECOVER.
                        grant   <= 8'd0;
                        timeout <= 1'b1;
                        state   <= ST_RECOVER;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RECOVER: begin
                    state <= ST_IDLE;
                end
                default: begin
                    grant <= 8'd0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prior_decoder3to8_seq.sv
// tb/tb_prior_decoder3to8_seq.sv - directed self-checking bench for prior_decoder3to8_seq
module tb_prior_decoder3to8_seq;

    logic       clk;
    logic       rst;
    logic       v;
    logic [2:0] y;
    logic       ready;
    logic [7:0] grant;
    logic [7:0] ack;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    prior_decoder3to8_seq #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .v       (v),
        .y       (y),
        .ready   (ready),
        .grant   (grant),
        .ack     (ack),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_order [8];

    initial begin
        exp_order = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        rst = 1'b1; v = 1'b0; y = 3'd0; ack = 8'd0;

        // Reset with a code presented: it must be discarded
        tick();
        v = 1'b1; y = 3'd7;
        tick();
        rst = 1'b0; v = 1'b0;
        check("rst_grant", grant, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_ready", ready, 1'b1);
        tick();
        check("rst_discard", grant, 8'h00);

        // Single code 5, ack two cycles into the grant
        v = 1'b1; y = 3'd5;
        tick();
        v = 1'b0;
        check("c5_not_yet", grant, 8'h00);
        tick();
        check("c5_grant", grant, 8'h20);
        check("c5_busy", busy, 1'b1);
        tick();
        check("c5_hold", grant, 8'h20);
        ack = 8'h20;
        tick();
        ack = 8'h00;
        check("c5_drop", grant, 8'h00);
        check("c5_recover_busy", busy, 1'b1);
        check("c5_no_timeout", timeout, 1'b0);
        tick();
        check("c5_idle_busy", busy, 1'b0);
        tick();
        check("c5_cleared", grant, 8'h00);

        // Codes 2 then 6: 2 is picked first, no preemption
        v = 1'b1; y = 3'd2;
        tick();
        y = 3'd6;
        tick();
        v = 1'b0;
        check("c26_first", grant, 8'h04);
        ack = 8'h04;
        tick();
        ack = 8'h00;
        check("c26_drop", grant, 8'h00);
        tick();
        check("c26_gap", grant, 8'h00);
        tick();
        check("c26_second", grant, 8'h40);
        ack = 8'h40;
        tick();
        ack = 8'h00;
        tick();
        check("c26_idle", busy, 1'b0);

        // Timeout with TIMEOUT=4 on code 3
        v = 1'b1; y = 3'd3;
        tick();
        v = 1'b0;
        tick();
        check("to_grant", grant, 8'h08);
        tick();
        tick();
        tick();
        check("to_last_cycle", grant, 8'h08);
        check("to_no_pulse_yet", timeout, 1'b0);
        tick();
        check("to_drop", grant, 8'h00);
        check("to_pulse", timeout, 1'b1);
        tick();
        check("to_pulse_end", timeout, 1'b0);
        check("to_gap", grant, 8'h00);
        tick();
        check("to_reissue", grant, 8'h08);
        ack = 8'h08;
        tick();
        ack = 8'h00;
        tick();
        check("to_idle", busy, 1'b0);

        // Foreign acks ignored; ack plus re-request keeps line pending
        v = 1'b1; y = 3'd1;
        tick();
        v = 1'b0;
        tick();
        check("fa_grant", grant, 8'h02);
        ack = 8'hFD;
        tick();
        check("fa_ignore1", grant, 8'h02);
        tick();
        check("fa_ignore2", grant, 8'h02);
        ack = 8'h02; v = 1'b1; y = 3'd1;
        tick();
        ack = 8'h00; v = 1'b0;
        check("fa_drop", grant, 8'h00);
        check("fa_no_timeout", timeout, 1'b0);
        tick();
        check("fa_gap", grant, 8'h00);
        tick();
        check("fa_reissue", grant, 8'h02);
        ack = 8'h02;
        tick();
        ack = 8'h00;
        tick();
        check("fa_idle", busy, 1'b0);

        // All eight codes, 7 down to 0 on consecutive edges
        v = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            y = 3'(k);
            tick();
        end
        check("all_ready_before_full", ready, 1'b1);
        y = 3'd0;
        tick();
        v = 1'b0;
        check("all_ready_full", ready, 1'b0);
        for (int g = 0; g < 8; g++) begin
            for (int w = 0; w < 20 && grant == 8'h00; w++) begin
                tick();
            end
            check($sformatf("all_order_%0d", g), grant, exp_order[g]);
            ack = exp_order[g];
            tick();
            ack = 8'h00;
        end
        check("all_ready_after", ready, 1'b1);
        tick();
        check("all_idle", busy, 1'b0);

        // Reset in the middle of a grant
        v = 1'b1; y = 3'd4;
        tick();
        v = 1'b0;
        tick();
        check("mr_grant", grant, 8'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_drop", grant, 8'h00);
        check("mr_no_timeout", timeout, 1'b0);
        check("mr_busy", busy, 1'b0);
        tick();
        tick();
        check("mr_pending_clear", grant, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
